// File: rtl/seg_display_mux.sv
// Drives a multiplexed 3-digit 7-segment display from a 12-bit hex status word.
// Each digit owns one REFRESH_DIV-cycle slot. The first DEAD_CYCLES cycles of every
// slot are blank to suppress ghosting. The input is snapshotted once per frame so a
// frame never tears.
module seg_display_mux #(
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 64,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] seg_digits,
   input  logic [2:0]  dp_in,
   input  logic        blank_lz,
   output logic [7:0]  seg_out,
   output logic [2:0]  seg_en,
   output logic        frame_tick
);

   localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2
   } digit_t;

   logic [CW-1:0] cnt, cnt_nxt;
   digit_t        d, d_nxt;
   logic          frame_start;

   logic [11:0]   snap;
   logic [2:0]    dp_snap;
   logic          lz_snap;

   logic [3:0]    nib;
   logic          blank;
   logic          dp_bit;
   logic [2:0]    en_onehot;
   logic [6:0]    seg7;
   logic [7:0]    seg_logic;
   logic [2:0]    en_logic;

   assign frame_start = (cnt == '0) && (d == DIG0);

   // Slot counter and digit index registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         d   <= DIG0;
      end else begin
         cnt <= cnt_nxt;
         d   <= d_nxt;
      end
   end

   // Next slot position: the counter wraps at the end of a slot and the digit advances.
   always_comb begin
      cnt_nxt = cnt + CNT_ONE;
      d_nxt   = d;
      if (cnt == CNT_LAST) begin
         cnt_nxt = '0;
         case (d)
            DIG0:    d_nxt = DIG1;
            DIG1:    d_nxt = DIG2;
            default: d_nxt = DIG0;
         endcase
      end
   end

   // Latch the display inputs once per frame, at the start of digit 0's slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap    <= '0;
         dp_snap <= '0;
         lz_snap <= 1'b0;
      end else if (frame_start) begin
         snap    <= seg_digits;
         dp_snap <= dp_in;
         lz_snap <= blank_lz;
      end
   end

   // Select the current digit's nibble, blanking and dp, and decode to logical segments.
   always_comb begin
      nib       = snap[3:0];
      blank     = 1'b0;
      dp_bit    = dp_snap[0];
      en_onehot = 3'b001;
      case (d)
         DIG0: begin
            nib       = snap[11:8];
            blank     = lz_snap && (snap[11:8] == 4'h0);
            dp_bit    = dp_snap[2];
            en_onehot = 3'b100;
         end
         DIG1: begin
            nib       = snap[7:4];
            blank     = lz_snap && (snap[11:4] == 8'h00);
            dp_bit    = dp_snap[1];
            en_onehot = 3'b010;
         end
         default: ;
      endcase

      case (nib)
         4'h0: seg7 = 7'h3F;
         4'h1: seg7 = 7'h06;
         4'h2: seg7 = 7'h5B;
         4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;
         4'h5: seg7 = 7'h6D;
         4'h6: seg7 = 7'h7D;
         4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;
         4'h9: seg7 = 7'h6F;
         4'hA: seg7 = 7'h77;
         4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;
         4'hD: seg7 = 7'h5E;
         4'hE: seg7 = 7'h79;
         default: seg7 = 7'h71;
      endcase

      seg_logic = {dp_bit, blank ? 7'h00 : seg7};
      en_logic  = en_onehot;
      if (cnt < CNT_DEAD) begin
         seg_logic = '0;
         en_logic  = '0;
      end
   end

   // Output register: pin polarity is applied here so every pin is glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_out    <= {8{ACTIVE_LOW}};
         seg_en     <= {3{ACTIVE_LOW}};
         frame_tick <= 1'b0;
      end else begin
         seg_out    <= seg_logic ^ {8{ACTIVE_LOW}};
         seg_en     <= en_logic ^ {3{ACTIVE_LOW}};
         frame_tick <= frame_start;
      end
   end

endmodule

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
- Consumes the 12-bit, 3-hex-digit status word from the status encoder and drives the board's multiplexed 3-digit 7-segment display.
- Time-multiplexes the digits with a programmable refresh rate and a dead-time interval to suppress ghosting.
- Snapshots the input once per frame so digits never tear mid-frame.
- Optional leading-zero blanking and per-digit decimal points.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot (100 MHz -> 2 kHz per digit); must be >= 2
DEAD_CYCLES, 64, cycles at the start of each slot with all digits disabled; 1 <= DEAD_CYCLES < REFRESH_DIV
ACTIVE_LOW, 1, 1: seg_out and seg_en are active-low on the pins; 0: active-high

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
seg_digits  in  12  [11:8] leftmost digit (digit 0), [7:4] digit 1, [3:0] rightmost digit (digit 2)
dp_in  in  3  decimal point enable; bit 2 = digit 0, bit 0 = digit 2
blank_lz  in  1  1 = blank leading zero digits
seg_out  out  8  {dp,g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
seg_en  out  3  digit enables; bit 2 = digit 0, polarity per ACTIVE_LOW
frame_tick  out  1  one-cycle pulse marking the start of digit 0's slot

Behaviour:
- State: slot counter cnt (0..REFRESH_DIV-1), digit index d (0,1,2), 12-bit snapshot, 3-bit dp snapshot. All outputs registered.
- Reset (async, immediate):
  - cnt=0, d=0, snapshots=0, frame_tick=0.
  - seg_en all inactive and seg_out all inactive (0x00 logical; 0xFF on pins when ACTIVE_LOW=1).
- Counting:
  - cnt increments each cycle.
  - At cnt==REFRESH_DIV-1, cnt wraps to 0 and d advances 0->1->2->0.
- Snapshot:
  - On the edge where cnt==0 and d==0, seg_digits and dp_in are latched. This includes the first cycle after reset release.
  - Input changes after that edge are not shown until the next frame.
- Registered outputs, computed each edge from pre-edge state:
  - If cnt < DEAD_CYCLES: seg_en all inactive, seg_out all inactive.
  - Otherwise: only seg_en[2-d] active; seg_out = decode(nibble d of the snapshot) with dp = dp snapshot bit for d.
  - Net effect: the pins show the slot's first DEAD_CYCLES cycles blank, delayed by one cycle.
  - Because DEAD_CYCLES >= 1, a digit is never shown using a snapshot value from the previous frame.
- frame_tick: registered; high for exactly one cycle, on the cycle after the edge where cnt==0 and d==0.
- Decode (logical, active-high), hex digit -> segment code:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - ACTIVE_LOW=1 inverts all 8 seg_out bits and all 3 seg_en bits at the output register.
- Leading-zero blanking (blank_lz sampled with the snapshot):
  - Digit 0 is blanked when its nibble is 0.
  - Digit 1 is blanked when both digit 0 and digit 1 nibbles are 0.
  - Digit 2 is never blanked.
  - A blanked digit has segments a-g off but its enable still asserts, and its dp still follows dp_in.
- Frame length: 3*REFRESH_DIV cycles. Each digit is lit for REFRESH_DIV-DEAD_CYCLES cycles per frame.
- Reset mid-slot: outputs go inactive asynchronously. After release, scanning restarts at digit 0 with a fresh snapshot and frame_tick.

Test Plan:
- Params REFRESH_DIV=8, DEAD_CYCLES=2, ACTIVE_LOW=1; seg_digits=0x2A5, dp_in=0, blank_lz=0; release reset.
  -> frame_tick every 24 cycles.
  -> seg_en pins 011 shows seg_out=~0x5B=0xA4 for 6 cycles; then 101 with ~0x77=0x88; then 110 with ~0x6D=0x92.
  -> 2 all-off cycles (seg_en=111, seg_out=0xFF) before each digit.
- Asserting rst mid-digit-1 -> seg_en=111 and seg_out=0xFF in the same cycle without a clock edge.
  -> After release: frame_tick one cycle later, then digit 0 sequence as above.
- seg_digits changes 0x2A5->0x123 during digit 1's lit window.
  -> Digits 1 and 2 still show A and 5 this frame; next frame shows 1, 2, 3.
- blank_lz=1 with seg_digits=0x007 -> digits 0 and 1 show seg_out=0xFF while enabled; digit 2 shows ~0x07=0xF8.
  -> With 0x070: only digit 0 blanked.
- dp_in=3'b010, seg_digits=0x888 -> digit 1 shows ~0xFF=0x00; digits 0 and 2 show ~0x7F=0x80.
- ACTIVE_LOW=0, seg_digits=0xF0C -> enables active-high one-hot (100, 010, 001); segments 0x71, 0x3F, 0x39; reset values seg_en=000, seg_out=0x00.
